// File: rtl/bus_copy_dma.sv
// rtl/bus_copy_dma.sv - chunked block-copy bus initiator for the sel/ack memory handshake
//
// Copies len_i 32-bit words from src_addr_i to dst_addr_i (word addresses).
// Each chunk of up to BURST words is first read into a local buffer and then
// written out. Every access drops sel_o for one cycle before the next one.
//
// Ports:
//   clk          system clock
//   reset_i      synchronous active-high reset
//   start_i      one-cycle start request, honoured only in IDLE
//   src_addr_i   source word address
//   dst_addr_i   destination word address
//   len_i        number of words to copy (0 completes with no bus activity)
//   busy_o       transfer in progress
//   done_o       one-cycle completion pulse
//   sel_o        bus request, held until ack_i
//   wr_en_o      1 = write, 0 = read
//   wr_mask_o    byte enables, constant 4'hF
//   address_o    word address of the current access
//   data_o       write data
//   data_in_i    read data, valid while ack_i = 1
//   ack_i        one-cycle acknowledge

module bus_copy_dma #(
    parameter int BURST = 8,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             sel_o,
    output logic             wr_en_o,
    output logic [3:0]       wr_mask_o,
    output logic [31:0]      address_o,
    output logic [31:0]      data_o,
    input  logic [31:0]      data_in_i,
    input  logic             ack_i
);

    // Chunk and index counters must hold the value BURST itself.
    localparam int CW = $clog2(BURST) + 1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_GAP,
        WR,
        WR_GAP,
        FIN
    } state_t;

    state_t           state_q;
    logic [31:0]      cur_src_q;
    logic [31:0]      cur_dst_q;
    logic [LEN_W-1:0] remaining_q;
    logic [CW-1:0]    chunk_q;
    logic [CW-1:0]    idx_q;
    logic [31:0]      buf_mem_q [BURST];

    logic             sel_q;
    logic             wr_en_q;
    logic             busy_q;
    logic             done_q;
    logic [31:0]      address_q;
    logic [31:0]      data_q;

    logic [LEN_W-1:0] remaining_d;
    logic [CW-1:0]    idx_d;
    logic [31:0]      next_src_d;
    logic [31:0]      next_dst_d;

    function automatic logic [CW-1:0] chunk_of(input logic [LEN_W-1:0] n);
        if (n >= LEN_W'(BURST)) begin
            return CW'(BURST);
        end
        return n[CW-1:0];
    endfunction

    // Values the chunk bookkeeping takes once the last write of a chunk is acked.
    assign remaining_d = remaining_q - LEN_W'(chunk_q);
    assign next_src_d  = cur_src_q + 32'(chunk_q);
    assign next_dst_d  = cur_dst_q + 32'(chunk_q);
    assign idx_d       = idx_q + CW'(1);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            address_q   <= '0;
            data_q      <= '0;
            cur_src_q   <= '0;
            cur_dst_q   <= '0;
            remaining_q <= '0;
            chunk_q     <= '0;
            idx_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cur_src_q   <= src_addr_i;
                        cur_dst_q   <= dst_addr_i;
                        remaining_q <= len_i;
                        idx_q       <= '0;
                        if (len_i == '0) begin
                            state_q <= FIN;
                        end else begin
                            chunk_q   <= chunk_of(len_i);
                            sel_q     <= 1'b1;
                            wr_en_q   <= 1'b0;
                            address_q <= src_addr_i;
                            busy_q    <= 1'b1;
                            state_q   <= RD;
                        end
                    end
                end
                RD: begin
                    if (ack_i) begin
                        buf_mem_q[idx_q[CW-2:0]] <= data_in_i;
                        sel_q   <= 1'b0;
                        idx_q   <= idx_d;
                        state_q <= RD_GAP;
                    end
                end
                RD_GAP: begin
                    if (idx_q < chunk_q) begin
                        sel_q     <= 1'b1;
                        address_q <= cur_src_q + 32'(idx_q);
                        state_q   <= RD;
                    end else begin
                        idx_q     <= '0;
                        sel_q     <= 1'b1;
                        wr_en_q   <= 1'b1;
                        address_q <= cur_dst_q;
                        data_q    <= buf_mem_q[0];
                        state_q   <= WR;
                    end
                end
                WR: begin
                    if (ack_i) begin
                        sel_q   <= 1'b0;
                        idx_q   <= idx_d;
                        state_q <= WR_GAP;
                    end
                end
                WR_GAP: begin
                    if (idx_q < chunk_q) begin
                        sel_q     <= 1'b1;
                        address_q <= cur_dst_q + 32'(idx_q);
                        data_q    <= buf_mem_q[idx_q[CW-2:0]];
                        state_q   <= WR;
                    end else begin
                        remaining_q <= remaining_d;
                        cur_src_q   <= next_src_d;
                        cur_dst_q   <= next_dst_d;
                        idx_q       <= '0;
                        wr_en_q     <= 1'b0;
                        if (remaining_d != '0) begin
                            // Next chunk starts exactly like a fresh transfer.
                            chunk_q   <= chunk_of(remaining_d);
                            sel_q     <= 1'b1;
                            address_q <= next_src_d;
                            state_q   <= RD;
                        end else begin
                            state_q <= FIN;
                        end
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign sel_o     = sel_q;
    assign wr_en_o   = wr_en_q;
    assign wr_mask_o = 4'hF;
    assign address_o = address_q;
    assign data_o    = data_q;

endmodule

// File: doc/bus_copy_dma.md
Name: bus_copy_dma

Overview:
- Bus initiator for the CPU-side memory handshake: sel held until a one-cycle ack, word addressing, read data valid with ack.
- Copies a block of 32-bit words from a source word address to a destination word address.
- Works in chunks of up to BURST words: reads the chunk into a local buffer, then writes it out.
- Sits beside the CPU on the memory bus (through the system arbiter) to offload framebuffer and memory block moves.

Parameters:
- BURST, 8, local buffer depth in words; power of two, >= 2.
- LEN_W, 16, width of the transfer length in words.

Ports:
- clk  input  1  system clock
- reset_i  input  1  synchronous active-high reset
- start_i  input  1  one-cycle start request; accepted only when idle
- src_addr_i  input  32  source word address (bit 0 = one 32-bit word)
- dst_addr_i  input  32  destination word address
- len_i  input  LEN_W  number of words to copy
- busy_o  output  1  transfer in progress
- done_o  output  1  one-cycle pulse when the transfer completes
- sel_o  output  1  bus request
- wr_en_o  output  1  1 = write, 0 = read
- wr_mask_o  output  4  byte enables; always 4'hF
- address_o  output  32  word address of the current access
- data_o  output  32  write data
- data_in_i  input  32  read data; valid in the cycle ack_i=1
- ack_i  input  1  one-cycle transaction acknowledge

Behaviour:
- Reset: state IDLE; sel_o, wr_en_o, busy_o, done_o = 0; address_o, data_o = 0; wr_mask_o = 4'hF; counters cleared. Buffer contents are don't-care.
- All bus outputs are registered.
- States: IDLE, RD, RD_GAP, WR, WR_GAP, FIN.
- IDLE, start_i=1:
  - Latch src, dst and len into cur_src, cur_dst and remaining.
  - If len=0: go to FIN; no bus activity.
  - Otherwise: chunk = min(BURST, remaining); idx = 0; sel_o<=1, wr_en_o<=0, address_o<=src; busy_o<=1; go to RD.
  - sel_o is therefore high on the cycle after start.
- RD:
  - sel_o, address_o and wr_en_o are held stable until ack_i.
  - On ack_i: buf[idx]<=data_in_i; sel_o<=0; idx++; go to RD_GAP.
- RD_GAP: sel_o is low for exactly one cycle.
  - If idx<chunk: sel_o<=1, address_o<=cur_src+idx; go to RD.
  - Else: idx<=0; sel_o<=1, wr_en_o<=1, address_o<=cur_dst, data_o<=buf[0]; go to WR.
- WR: outputs held stable until ack_i; on ack_i: sel_o<=0, idx++; go to WR_GAP.
- WR_GAP:
  - If idx<chunk: issue the next write at cur_dst+idx with buf[idx]; go to WR.
  - Else: remaining-=chunk; cur_src+=chunk; cur_dst+=chunk.
    - If the new remaining>0: start the next chunk's first read (as at start); go to RD.
    - Else: go to FIN.
- FIN: done_o<=1 for one cycle, busy_o<=0 in that same cycle; go to IDLE.
- Handshake rules:
  - sel_o is never high in two consecutive transactions without an intervening low cycle. This is required because the responder would otherwise start a new access.
  - ack_i while sel_o=0 is ignored.
  - ack_i in the same cycle sel_o rises is a valid ack.
- Address arithmetic is modulo 2^32: addresses wrap from 0xFFFF_FFFF to 0x0000_0000 with no error.
- Source and destination ranges may overlap. The copy is forward in chunk order; no overlap correction is performed.
- start_i while busy_o=1 or in FIN is ignored; latched parameters are unchanged.
- A reset mid-transfer returns to IDLE, with sel_o=0 on the cycle after reset is sampled. No done_o is generated and the transfer is abandoned.
- Read-modify-write is not needed; wr_mask_o is always 4'hF.

Test Plan:
- len_i=0, start pulse -> no sel_o activity; done_o=1 exactly 2 cycles after start with busy_o=0.
- src=0x100, dst=0x200, len=3, responder acks 2 cycles after sel rises and returns data=addr^0xA5A5A5A5 -> reads at 0x100, 0x101, 0x102, then writes at 0x200, 0x201, 0x202 with matching data. Each sel_o pulse ends the cycle after ack, with one low cycle between accesses.
- len=10, BURST=8 -> 8 reads, 8 writes, 2 reads, 2 writes. Second chunk addresses are src+8 and dst+8; one done_o pulse at the end.
- src=0xFFFF_FFFE, dst=0x10, len=4 -> reads at 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0, 0x1; writes at 0x10 through 0x13.
- Random ack latency 0-5 plus spurious ack_i while sel_o=0 -> data integrity preserved; spurious acks are not counted.
- start_i re-pulsed while busy is ignored. reset_i asserted during WR -> sel_o=0 and busy_o=0 on the next cycle, no done_o; a subsequent start with len=2 completes normally.
